// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: writeback has priority, long-latency writes are buffered
// and drained into idle cycles. Define RFWA_BYPASS_EN for zero-latency LL writes when idle.
module rf_wport_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned RF_ADDR_WIDTH = 5,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_RegWriteWB,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegWB,
  input  logic [DATA_WIDTH-1:0]    i_ResultWB,
  input  logic                     i_LLValid,
  input  logic [RF_ADDR_WIDTH-1:0] i_LLReg,
  input  logic [DATA_WIDTH-1:0]    i_LLData,
  output logic                     o_LLReady,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtD,
  output logic                     o_RegWriteW,
  output logic [RF_ADDR_WIDTH-1:0] o_WriteRegW,
  output logic [DATA_WIDTH-1:0]    o_ResultW,
  output logic                     o_PendHitD,
  output logic                     o_StallReq
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SCNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SCNT_W-1:0] LIMIT  = SCNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0]  DEPTHC = CNT_W'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STALL} state_t;

  logic [RF_ADDR_WIDTH-1:0] r_fifo_reg  [DEPTH];
  logic [DATA_WIDTH-1:0]    r_fifo_data [DEPTH];
  logic [PTR_W-1:0]         r_wptr, r_rptr;
  logic [CNT_W-1:0]         r_count;
  logic [SCNT_W-1:0]        r_starve;
  state_t                   r_state;

  logic             w_wb_req, w_empty, w_full, w_head_gnt, w_byp, w_enq, w_deq;
  logic [CNT_W-1:0] w_count_next;

  assign w_wb_req   = i_RegWriteWB && (i_WriteRegWB != '0);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTHC);
  assign w_head_gnt = !w_wb_req && !w_empty;
  assign w_deq      = w_head_gnt;
  assign o_LLReady  = !w_full;

`ifdef RFWA_BYPASS_EN
  assign w_byp = !w_wb_req && w_empty && i_LLValid && (i_LLReg != '0);
`else
  assign w_byp = 1'b0;
`endif

  // LL writes to register 0 complete the handshake but are dropped here
  assign w_enq = i_LLValid && !w_full && (i_LLReg != '0) && !w_byp;

  always_comb begin
    w_count_next = r_count;
    if (w_enq && !w_deq) w_count_next = r_count + CNT_W'(1);
    else if (!w_enq && w_deq) w_count_next = r_count - CNT_W'(1);
  end

  // Write-port mux: WB, then FIFO head, then (optionally) same-cycle LL bypass
  always_comb begin
    o_RegWriteW = 1'b0;
    o_WriteRegW = '0;
    o_ResultW   = '0;
    if (w_wb_req) begin
      o_RegWriteW = 1'b1;
      o_WriteRegW = i_WriteRegWB;
      o_ResultW   = i_ResultWB;
    end else if (!w_empty) begin
      o_RegWriteW = 1'b1;
      o_WriteRegW = r_fifo_reg[r_rptr];
      o_ResultW   = r_fifo_data[r_rptr];
    end else if (w_byp) begin
      o_RegWriteW = 1'b1;
      o_WriteRegW = i_LLReg;
      o_ResultW   = i_LLData;
    end
  end

  // Entry i is live when its distance from the read pointer is below the count
  always_comb begin
    o_PendHitD = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      logic [PTR_W-1:0] w_off;
      w_off = PTR_W'(i) - r_rptr;
      if ((CNT_W'(w_off) < r_count) &&
          (((i_RsD != '0) && (i_RsD == r_fifo_reg[i])) ||
           ((i_RtD != '0) && (i_RtD == r_fifo_reg[i]))))
        o_PendHitD = 1'b1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (w_enq) begin
      r_fifo_reg[r_wptr]  <= i_LLReg;
      r_fifo_data[r_wptr] <= i_LLData;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + PTR_W'(1);
      if (w_deq) r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_next;
    end
  end

  // Starvation tracker: counts consecutive cycles the buffered head loses to writeback
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      r_state  <= ST_IDLE;
      r_starve <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_starve <= '0;
          if (w_count_next != '0) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_head_gnt) begin
            r_starve <= '0;
            if (w_count_next == '0) r_state <= ST_IDLE;
          end else if (w_empty) begin
            r_starve <= '0;
            r_state  <= ST_IDLE;
          end else begin
            r_starve <= r_starve + SCNT_W'(1);
            if (r_starve + SCNT_W'(1) >= LIMIT) r_state <= ST_STALL;
          end
        end
        ST_STALL: begin
          if (w_head_gnt) begin
            r_starve <= '0;
            r_state  <= (w_count_next == '0) ? ST_IDLE : ST_WAIT;
          end
        end
        default: begin
          r_starve <= '0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_StallReq = (r_state == ST_STALL);

endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Shares the single register-file write port (write address, write enable, write data) between the in-order writeback stage and one long-latency requester (multi-cycle multiply/divide or late load return). Writeback always has priority; long-latency writes are buffered in a small FIFO and drained into idle write-port cycles. The block also flags decode-stage RAW hazards against buffered writes and requests a pipeline stall when the buffer starves. Its outputs drive the decode stage's register-file write inputs directly.

## Interface
- DATA_WIDTH, 32, write-data width
- RF_ADDR_WIDTH, 5, register address width
- DEPTH, 4, FIFO entries; power of 2, ≥2
- STARVE_LIMIT, 8, consecutive denied cycles before stall request; ≥1
- i_CLK  in  1  clock, rising edge
- i_RST  in  1  asynchronous, active-low reset
- i_RegWriteWB  in  1  writeback stage write enable
- i_WriteRegWB  in  RF_ADDR_WIDTH  writeback destination
- i_ResultWB  in  DATA_WIDTH  writeback data
- i_LLValid  in  1  long-latency write request valid
- i_LLReg  in  RF_ADDR_WIDTH  long-latency destination
- i_LLData  in  DATA_WIDTH  long-latency data
- o_LLReady  out  1  FIFO can accept
- i_RsD, i_RtD  in  RF_ADDR_WIDTH each  decode-stage source addresses
- o_RegWriteW  out  1  to register file write enable
- o_WriteRegW  out  RF_ADDR_WIDTH  to register file write address
- o_ResultW  out  DATA_WIDTH  to register file write data
- o_PendHitD  out  1  decode source matches a buffered write
- o_StallReq  out  1  stall request to hazard unit

## Operation
- WB effective request = i_RegWriteWB && i_WriteRegWB != 0. LL writes to register 0 are accepted by the handshake and discarded (never enqueued).
- Grant priority: WB request > FIFO head > (bypass, see Configuration). Non-granted output: o_RegWriteW=0, address/data 0.
- Enqueue on rising edge when i_LLValid && o_LLReady && i_LLReg != 0. o_LLReady = !full (does not account for same-cycle dequeue).
- Dequeue head on the edge of the cycle in which it is granted. Simultaneous enqueue+dequeue keeps count unchanged; pointers wrap modulo DEPTH.
- o_PendHitD = 1 when i_RsD (nonzero) or i_RtD (nonzero) equals the destination of any valid FIFO entry; combinational.
- Starvation FSM, states IDLE / WAIT / STALL, counter width clog2(STARVE_LIMIT+1):
  - IDLE: FIFO empty; counter 0. FIFO non-empty next cycle → WAIT.
  - WAIT: each cycle with head denied (WB granted) counter +1; head granted → counter 0. Counter reaches STARVE_LIMIT → STALL. FIFO empty → IDLE.
  - STALL: o_StallReq=1. Head granted → counter 0, WAIT (or IDLE if FIFO now empty).
- Multiple buffered writes to same register retire in FIFO order; last written value wins.

## Timing
- Reset (async assert, sync-safe deassert): FIFO empty, pointers 0, counter 0, state IDLE; o_LLReady=1, o_StallReq=0, o_PendHitD=0, o_RegWriteW=0.
- Write-port outputs combinational from current WB inputs and FIFO head; zero added latency for WB writes.
- LL write minimum latency: handshake edge → appears on port next cycle (without bypass).
- o_StallReq registered (state-derived); asserted the cycle after the counter reaches STARVE_LIMIT.
- Reset mid-operation discards all buffered writes.

## Configuration
- RFWA_BYPASS_EN defined: when WB not requesting, FIFO empty, and i_LLValid with nonzero i_LLReg, the LL write is driven onto the port the same cycle and not enqueued (zero latency).
- Undefined: all LL writes go through the FIFO; minimum latency one cycle.

## Test plan
- Reset then idle: o_LLReady=1, o_RegWriteW=0, o_StallReq=0, all outputs 0.
- LL write reg 9 = 0xDEADBEEF, WB idle: port shows reg 9/0xDEADBEEF next cycle (same cycle with RFWA_BYPASS_EN); o_PendHitD=1 for i_RsD=9 while buffered.
- WB writes every cycle, 4 LL writes (regs 1-4): o_LLReady drops after 4th; after 8 denied cycles o_StallReq=1; one WB bubble → reg 1 written, o_StallReq deasserts.
- Same-cycle WB reg 5 and LL reg 6: port writes reg 5; reg 6 written first idle cycle after.
- LL writes reg 7=1 then reg 7=2: port writes 1 then 2 in order; LL write to reg 0 never appears on port; WB write to reg 0 never grants.
- Assert i_RST with 3 entries buffered: FIFO cleared immediately, no further writes issued, o_LLReady=1.
